rat_path_tracer: RTL and testbench

- Sits directly downstream of the intelligent-rat solver and consumes its Move stream.
- Buffers moves in a FIFO and replays them at a paced rate, integrating each move into an (X,Y) position on the 16x16 maze.
- Emits position updates for display or logging, and reports path length, goal arrival and error conditions.

---
 rtl/rat_pkg.sv | 31 +++
 rtl/rat_move_fifo.sv | 62 ++++++
 rtl/rat_path_tracer.sv | 159 +++++++++++++++
 tb/tb_rat_path_tracer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// rat_pkg: shared types and constants for the rat path tracer.
//   move_t  - 2-bit move encoding produced by the maze solver
//   err_t   - error code reported on ErrCode
//   state_t - tracer control states
//   MAZE_MAX - largest coordinate of the default 16x16 maze
package rat_pkg;

  localparam int MAZE_MAX = 15;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OOB  = 2'b01,
    ERR_FAIL = 2'b10,
    ERR_OVF  = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10,
    ERROR  = 2'b11
  } state_t;

endpackage

// File: rtl/rat_move_fifo.sv
// rat_move_fifo: synchronous FIFO holding solver moves.
//   Clk, Rst      - clock, synchronous active-high reset
//   flush_i       - empties the FIFO (wins over push/pop)
//   push_i        - write push_data_i when not full
//   pop_i         - advance the head when not empty
//   pop_data_o    - head entry (valid while not empty)
//   full_o/empty_o - derived from the registered occupancy
module rat_move_fifo
  import rat_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  Clk,
  input  logic  Rst,
  input  logic  flush_i,
  input  logic  push_i,
  input  move_t push_data_i,
  input  logic  pop_i,
  output move_t pop_data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Small 2-bit-wide store; read asynchronously so the head is visible
  // in the same cycle the pacer decides to pop it.
  move_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           push_ok;
  logic           pop_ok;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rat_path_tracer.sv
// rat_path_tracer: buffers the solver's move stream and replays it at a
// paced rate, integrating each move into an (X,Y) maze position.
//   Clk, Rst             - clock, synchronous active-high reset
//   Start                - one-cycle pulse, begins a new trace
//   MoveValid/Move       - incoming solver move, accepted when MoveReady
//   MoveReady            - high in ACTIVE while the FIFO is not full
//   RatDone / RatFail    - solver end-of-path / no-path indications
//   PosX, PosY, PosValid - replayed position and its one-cycle strobe
//   StepCount            - moves replayed (never exceeds 255)
//   Finished, AtGoal     - clean completion, and completion at the corner
//   ErrCode              - none / out-of-bounds / rat fail / step overflow
module rat_path_tracer
  import rat_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 4,
  parameter int CW          = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic          MoveValid,
  input  logic [1:0]    Move,
  output logic          MoveReady,
  input  logic          RatDone,
  input  logic          RatFail,
  output logic [CW-1:0] PosX,
  output logic [CW-1:0] PosY,
  output logic          PosValid,
  output logic [7:0]    StepCount,
  output logic          Finished,
  output logic          AtGoal,
  output logic [1:0]    ErrCode
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] POS_MAX = '1;

  state_t        state_q;
  logic [PW-1:0] pace_q;
  logic          end_q;
  logic          pend_q;       // a popped move waiting to be integrated
  move_t         pend_move_q;
  logic [CW-1:0] pos_x_q, pos_y_q;
  logic          pos_valid_q;
  logic [7:0]    step_q;
  err_t          err_q;
  logic          finished_q, at_goal_q;

  logic          active, tick;
  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  move_t         fifo_head;
  logic [CW-1:0] next_x, next_y;
  logic          next_oob;

  assign active     = (state_q == ACTIVE);
  assign tick       = (pace_q == PW'(STEP_CYCLES - 1));
  // Start and RatFail flush the FIFO, so pushes/pops in those cycles are moot.
  assign fifo_flush = Start | (active & RatFail);
  assign fifo_push  = active & MoveValid & ~Start;
  assign fifo_pop   = active & tick & ~fifo_empty & ~RatFail & ~Start;

  rat_move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Rst         (Rst),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (move_t'(Move)),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next position for the pending move, with edge detection in place of
  // a wider signed adder.
  always_comb begin
    next_x   = pos_x_q;
    next_y   = pos_y_q;
    next_oob = 1'b0;
    case (pend_move_q)
      UP:      if (pos_y_q == '0)      next_oob = 1'b1; else next_y = pos_y_q - 1'b1;
      RIGHT:   if (pos_x_q == POS_MAX) next_oob = 1'b1; else next_x = pos_x_q + 1'b1;
      LEFT:    if (pos_x_q == '0)      next_oob = 1'b1; else next_x = pos_x_q - 1'b1;
      default: if (pos_y_q == POS_MAX) next_oob = 1'b1; else next_y = pos_y_q + 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      pace_q      <= '0;
      end_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_move_q <= UP;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_valid_q <= 1'b0;
      step_q      <= '0;
      err_q       <= ERR_NONE;
      finished_q  <= 1'b0;
      at_goal_q   <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      if (Start) begin
        state_q    <= ACTIVE;
        pace_q     <= '0;
        end_q      <= 1'b0;
        pend_q     <= 1'b0;
        pos_x_q    <= '0;
        pos_y_q    <= '0;
        step_q     <= '0;
        err_q      <= ERR_NONE;
        finished_q <= 1'b0;
        at_goal_q  <= 1'b0;
      end else if (state_q == ACTIVE) begin
        pace_q <= tick ? '0 : pace_q + 1'b1;
        if (RatFail) begin
          // Any pop this cycle or move still pending is dropped.
          err_q   <= ERR_FAIL;
          state_q <= ERROR;
          pend_q  <= 1'b0;
        end else begin
          if (RatDone) end_q <= 1'b1;
          pend_q <= fifo_pop;
          if (fifo_pop) pend_move_q <= fifo_head;
          if (pend_q) begin
            if (step_q == 8'hFF) begin
              err_q   <= ERR_OVF;
              state_q <= ERROR;
            end else if (next_oob) begin
              err_q   <= ERR_OOB;
              state_q <= ERROR;
            end else begin
              pos_x_q     <= next_x;
              pos_y_q     <= next_y;
              pos_valid_q <= 1'b1;
              step_q      <= step_q + 1'b1;
            end
          end else if (end_q && fifo_empty && !fifo_pop) begin
            state_q    <= DONE;
            finished_q <= 1'b1;
            at_goal_q  <= (pos_x_q == POS_MAX) && (pos_y_q == POS_MAX);
          end
        end
      end
    end
  end

  assign MoveReady = active & ~fifo_full;
  assign PosX      = pos_x_q;
  assign PosY      = pos_y_q;
  assign PosValid  = pos_valid_q;
  assign StepCount = step_q;
  assign Finished  = finished_q;
  assign AtGoal    = at_goal_q;
  assign ErrCode   = err_q;

endmodule

// File: tb/tb_rat_path_tracer.sv
module tb_rat_path_tracer;
  import rat_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fast instance (STEP_CYCLES=4) signals
  logic       rst, start, mv, rdone, rfail;
  logic [1:0] mv_data;
  logic       mready, pvalid, fin, goal;
  logic [3:0] px, py;
  logic [7:0] steps;
  logic [1:0] err;

  // Slow instance (STEP_CYCLES=64) signals
  logic       s_start, s_mv, s_rdone, s_rfail;
  logic [1:0] s_mv_data;
  logic       s_mready, s_pvalid, s_fin, s_goal;
  logic [3:0] s_px, s_py;
  logic [7:0] s_steps;
  logic [1:0] s_err;

  rat_path_tracer #(.DEPTH(16), .STEP_CYCLES(4), .CW(4)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start), .MoveValid(mv), .Move(mv_data),
    .MoveReady(mready), .RatDone(rdone), .RatFail(rfail), .PosX(px), .PosY(py),
    .PosValid(pvalid), .StepCount(steps), .Finished(fin), .AtGoal(goal), .ErrCode(err)
  );

  rat_path_tracer #(.DEPTH(16), .STEP_CYCLES(64), .CW(4)) u_slow (
    .Clk(clk), .Rst(rst), .Start(s_start), .MoveValid(s_mv), .Move(s_mv_data),
    .MoveReady(s_mready), .RatDone(s_rdone), .RatFail(s_rfail), .PosX(s_px), .PosY(s_py),
    .PosValid(s_pvalid), .StepCount(s_steps), .Finished(s_fin), .AtGoal(s_goal), .ErrCode(s_err)
  );

  typedef struct {int x; int y; int c;} pv_t;
  pv_t fq[$];
  pv_t sq[$];

  always @(negedge clk) begin
    if (pvalid === 1'b1) fq.push_back('{int'(px), int'(py), cyc});
    if (s_pvalid === 1'b1) sq.push_back('{int'(s_px), int'(s_py), cyc});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cw(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    fq.delete();
    start = 1'b1;
    cw(1);
    start = 1'b0;
  endtask

  // Presents a move on the fast instance and returns just after it is accepted.
  task automatic push_f(input logic [1:0] m);
    int t;
    t = 0;
    mv = 1'b1;
    mv_data = m;
    while (mready !== 1'b1 && t < 200) begin
      cw(1);
      t++;
    end
    if (t >= 200) chk("push_ready_timeout", t, 0);
    cw(1);
    mv = 1'b0;
  endtask

  int c_start, t, first_drop, ex, ey;

  initial begin
    rst = 1'b1; start = 0; mv = 0; mv_data = 0; rdone = 0; rfail = 0;
    s_start = 0; s_mv = 0; s_mv_data = 0; s_rdone = 0; s_rfail = 0;
    cw(3);

    // Reset state
    chk("rst_posx", int'(px), 0);
    chk("rst_posy", int'(py), 0);
    chk("rst_posvalid", int'(pvalid), 0);
    chk("rst_steps", int'(steps), 0);
    chk("rst_finished", int'(fin), 0);
    chk("rst_atgoal", int'(goal), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(mready), 0);
    rst = 1'b0;
    cw(2);
    chk("idle_ready", int'(mready), 0);

    // Basic path: right, right, down
    pulse_start();
    c_start = cyc;
    chk("active_ready", int'(mready), 1);
    push_f(2'b01); push_f(2'b01); push_f(2'b11);
    rdone = 1'b1; cw(1); rdone = 1'b0;
    cw(20);
    chk("t1_npos", fq.size(), 3);
    if (fq.size() == 3) begin
      chk("t1_p0x", fq[0].x, 1); chk("t1_p0y", fq[0].y, 0);
      chk("t1_p1x", fq[1].x, 2); chk("t1_p1y", fq[1].y, 0);
      chk("t1_p2x", fq[2].x, 2); chk("t1_p2y", fq[2].y, 1);
      chk("t1_first_latency", fq[0].c - c_start, 5);
      chk("t1_gap01", fq[1].c - fq[0].c, 4);
      chk("t1_gap12", fq[2].c - fq[1].c, 4);
    end
    chk("t1_steps", int'(steps), 3);
    chk("t1_finished", int'(fin), 1);
    chk("t1_atgoal", int'(goal), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_ready", int'(mready), 0);

    // Out of bounds: up from (0,0)
    pulse_start();
    chk("t2_restart_finished", int'(fin), 0);
    push_f(2'b00);
    cw(10);
    chk("t2_err", int'(err), 1);
    chk("t2_posx", int'(px), 0);
    chk("t2_posy", int'(py), 0);
    chk("t2_steps", int'(steps), 0);
    chk("t2_ready", int'(mready), 0);
    chk("t2_finished", int'(fin), 0);
    chk("t2_npos", fq.size(), 0);

    // RatFail after the first replayed move
    pulse_start();
    push_f(2'b01); push_f(2'b01); push_f(2'b01);
    t = 0;
    while (pvalid !== 1'b1 && t < 40) begin cw(1); t++; end
    chk("t4_first_pv_seen", int'(pvalid), 1);
    rfail = 1'b1; rdone = 1'b1; cw(1); rfail = 1'b0; rdone = 1'b0;
    cw(20);
    chk("t4_err", int'(err), 2);
    chk("t4_posx", int'(px), 1);
    chk("t4_posy", int'(py), 0);
    chk("t4_steps", int'(steps), 1);
    chk("t4_npos", fq.size(), 1);
    chk("t4_finished", int'(fin), 0);

    // Reset in the middle of a trace
    pulse_start();
    push_f(2'b01); push_f(2'b01);
    cw(12);
    chk("t5_pre_posx", int'(px), 2);
    rst = 1'b1; cw(1);
    chk("t5_state_idle", int'(u_dut.state_q), int'(IDLE));
    chk("t5_posx", int'(px), 0);
    chk("t5_steps", int'(steps), 0);
    chk("t5_ready", int'(mready), 0);
    chk("t5_err", int'(err), 0);
    rst = 1'b0;
    // Move offered while idle must be ignored
    mv = 1'b1; mv_data = 2'b01; cw(2); mv = 1'b0;
    pulse_start();
    push_f(2'b11);
    cw(8);
    chk("t5_posx_after", int'(px), 0);
    chk("t5_posy_after", int'(py), 1);
    chk("t5_steps_after", int'(steps), 1);

    // Full diagonal to the goal corner
    pulse_start();
    for (int i = 0; i < 15; i++) push_f(2'b01);
    for (int i = 0; i < 15; i++) push_f(2'b11);
    rdone = 1'b1; cw(1); rdone = 1'b0;
    t = 0;
    while (fin !== 1'b1 && t < 400) begin cw(1); t++; end
    chk("t6_finished", int'(fin), 1);
    chk("t6_posx", int'(px), MAZE_MAX);
    chk("t6_posy", int'(py), MAZE_MAX);
    chk("t6_steps", int'(steps), 30);
    chk("t6_atgoal", int'(goal), 1);
    chk("t6_err", int'(err), 0);

    // Step counter overflow: 256 moves oscillating right/left
    pulse_start();
    for (int i = 0; i < 256; i++) push_f((i % 2 == 0) ? 2'b01 : 2'b10);
    t = 0;
    while (err === 2'b00 && t < 2000) begin cw(1); t++; end
    chk("ovf_err", int'(err), 3);
    chk("ovf_steps", int'(steps), 255);
    chk("ovf_posx", int'(px), 1);
    chk("ovf_posy", int'(py), 0);
    chk("ovf_npos", fq.size(), 255);

    // Slow instance: FIFO fill and in-order replay
    sq.delete();
    s_start = 1'b1; cw(1); s_start = 1'b0;
    first_drop = -1;
    s_mv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_mv_data = (i % 2 == 0) ? 2'b01 : 2'b11;
      t = 0;
      while (s_mready !== 1'b1 && t < 300) begin
        if (first_drop < 0) first_drop = i;
        cw(1);
        t++;
      end
      if (t >= 300) chk("t3_push_timeout", t, 0);
      cw(1);
    end
    s_mv = 1'b0;
    chk("t3_accepted_before_drop", first_drop, 16);
    s_rdone = 1'b1; cw(1); s_rdone = 1'b0;
    t = 0;
    while (s_fin !== 1'b1 && t < 1600) begin cw(1); t++; end
    chk("t3_finished", int'(s_fin), 1);
    chk("t3_npos", sq.size(), 20);
    ex = 0; ey = 0;
    for (int i = 0; i < 20 && i < sq.size(); i++) begin
      if (i % 2 == 0) ex++; else ey++;
      chk($sformatf("t3_p%0dx", i), sq[i].x, ex);
      chk($sformatf("t3_p%0dy", i), sq[i].y, ey);
    end
    chk("t3_steps", int'(s_steps), 20);
    chk("t3_err", int'(s_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
